// File: rtl/trig_conditioner.sv
// External trigger conditioner: synchronizes and deglitches an active-low trigger,
// gates it through an enable/holdoff state machine and measures inter-trigger period.
module trig_conditioner #(
  parameter int FILTER_LEN     = 4,
  parameter int HOLDOFF_CYCLES = 500000,
  parameter int CNT_W          = 32
) (
  input  logic             sys_clk_i,
  input  logic             sys_rst_b_i,
  input  logic             ext_trig_b_i,
  input  logic             trig_en_i,
  output logic             trig_b_o,
  output logic             trig_pulse_o,
  output logic [CNT_W-1:0] period_o,
  output logic             period_valid_o,
  output logic [15:0]      reject_cnt_o
);

  localparam int              HO_W     = (HOLDOFF_CYCLES > 1) ? $clog2(HOLDOFF_CYCLES) : 1;
  localparam logic [HO_W-1:0] HO_LOAD  = HO_W'(HOLDOFF_CYCLES - 1);
  localparam logic [7:0]      RUN_LAST = 8'(FILTER_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_HIGH,
    ARMED,
    HOLDOFF
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync_p0;
  logic             sync_p1;
  logic [7:0]       run_p2;
  logic             trig_b_prev;
  logic             fall;
  logic             accept;
  logic [HO_W-1:0]  ho_cnt;
  logic [CNT_W-1:0] period_cnt;
  logic             first_seen;

  // Stage p0/p1: two-flop synchronizer, idles at the inactive (high) level
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_b_i) begin
      sync_p0 <= 1'b1;
      sync_p1 <= 1'b1;
    end else begin
      sync_p0 <= ext_trig_b_i;
      sync_p1 <= sync_p0;
    end
  end

  // Stage p2: level changes only after FILTER_LEN consecutive disagreeing samples
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_b_i) begin
      run_p2      <= '0;
      trig_b_o    <= 1'b1;
      trig_b_prev <= 1'b1;
    end else begin
      trig_b_prev <= trig_b_o;
      if (sync_p1 != trig_b_o) begin
        if (run_p2 == RUN_LAST) begin
          trig_b_o <= sync_p1;
          run_p2   <= '0;
        end else begin
          run_p2 <= run_p2 + 8'd1;
        end
      end else begin
        run_p2 <= '0;
      end
    end
  end

  assign fall   = trig_b_prev & ~trig_b_o;
  assign accept = (state == ARMED) && fall && trig_en_i;

  // Stage p3: acceptance state machine
  always_comb begin
    state_next = state;
    case (state)
      IDLE:      state_next = WAIT_HIGH;
      WAIT_HIGH: if (trig_b_o) state_next = ARMED;
      ARMED:     if (fall) state_next = HOLDOFF;
      HOLDOFF:   if (ho_cnt == '0) state_next = WAIT_HIGH;
      default:   state_next = IDLE;
    endcase
    if (!trig_en_i) state_next = IDLE;
  end

  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_b_i) begin
      state  <= IDLE;
      ho_cnt <= '0;
    end else begin
      state <= state_next;
      if (accept) begin
        ho_cnt <= HO_LOAD;
      end else if ((state == HOLDOFF) && (ho_cnt != '0)) begin
        ho_cnt <= ho_cnt - HO_W'(1);
      end
    end
  end

  // Stage p4: period measurement, strobes and reject counter
  always_ff @(posedge sys_clk_i) begin
    if (!sys_rst_b_i) begin
      period_cnt     <= '0;
      first_seen     <= 1'b0;
      period_o       <= '0;
      period_valid_o <= 1'b0;
      trig_pulse_o   <= 1'b0;
      reject_cnt_o   <= '0;
    end else begin
      trig_pulse_o   <= accept;
      period_valid_o <= accept && first_seen;
      if (accept && first_seen) begin
        period_o <= period_cnt;
      end
      if (state == IDLE) begin
        period_cnt <= '0;
        first_seen <= 1'b0;
      end else if (accept) begin
        period_cnt <= CNT_W'(1);
        first_seen <= 1'b1;
      end else if (period_cnt != '1) begin
        period_cnt <= period_cnt + CNT_W'(1);
      end
      if ((state == HOLDOFF) && fall && (reject_cnt_o != 16'hFFFF)) begin
        reject_cnt_o <= reject_cnt_o + 16'd1;
      end
    end
  end

endmodule
